// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix loader and the matrix multiplier.
// Contents:
//   clog2 / max_int  - constant helpers for sizing counters
//   state_t          - loader FSM encodings (LOAD_A, LOAD_B, FULL)
//   MAT_A_IDX / MAT_B_IDX - bit offset of element (row, col) inside the flat
//                      operand buses, shared with the multiplier
`ifndef MATRIZ_IDX_MACROS
`define MATRIZ_IDX_MACROS
`define MAT_A_IDX(i, k, m, w) ((((i) * (m)) + (k)) * (w))
`define MAT_B_IDX(k, j, p, w) ((((k) * (p)) + (j)) * (w))
`endif

package matriz_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    // Number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int res;
        res = 32'sd0;
        while ((32'sd1 << res) < value) begin
            res = res + 32'sd1;
        end
        return res;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cargador_matrices.sv
// Stream-to-matrix loader feeding the matrix multiplier.
// Elements arrive one per handshake, row-major, A (N x M) first then B (M x P).
// A completed pair is copied to the output bank (double-buffered) so the next
// pair can load while the current one is held for downstream.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   clr               - synchronous abort of the partial load
//   s_data/s_valid/s_ready - element input handshake
//   mat_a, mat_b      - flat operand buses (element (r,c) at (r*cols+c)*Bit)
//   m_valid/m_ready   - output pair handshake
module cargador_matrices
    import matriz_pkg::*;
#(
    parameter int Bit = 3,
    parameter int M   = 4,
    parameter int N   = 2,
    parameter int P   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [Bit-1:0]     s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [N*M*Bit-1:0] mat_a,
    output logic [M*P*Bit-1:0] mat_b,
    output logic               m_valid,
    input  logic               m_ready
);

    localparam int AW = N * M * Bit;
    localparam int BW = M * P * Bit;
    localparam int CW = max_int(1, clog2(max_int(N * M, M * P)));
    localparam logic [CW-1:0] LAST_A = CW'(N * M - 1);
    localparam logic [CW-1:0] LAST_B = CW'(M * P - 1);

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic [AW-1:0]   work_a_r, work_a_nxt_s;
    logic [BW-1:0]   work_b_r, work_b_nxt_s;
    logic            accept_s;
    logic            load_s;

    assign s_ready = (state_r != FULL);

    // Next-state, counter, working-register writes and output-bank load strobe.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        work_a_nxt_s = work_a_r;
        work_b_nxt_s = work_b_r;
        load_s       = 1'b0;
        // clr drops any element offered on the same edge
        accept_s     = s_valid && (state_r != FULL) && !clr;

        if (clr) begin
            state_nxt_s = LOAD_A;
            cnt_nxt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                LOAD_A: begin
                    if (accept_s) begin
                        work_a_nxt_s[int'(cnt_r) * Bit +: Bit] = s_data;
                        if (cnt_r == LAST_A) begin
                            cnt_nxt_s   = {CW{1'b0}};
                            state_nxt_s = LOAD_B;
                        end else begin
                            cnt_nxt_s   = cnt_r + CW'(1);
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                LOAD_B: begin
                    if (accept_s) begin
                        work_b_nxt_s[int'(cnt_r) * Bit +: Bit] = s_data;
                        if (cnt_r == LAST_B) begin
                            cnt_nxt_s = {CW{1'b0}};
                            // Slot is free if empty or being drained this edge
                            if (!m_valid || m_ready) begin
                                load_s      = 1'b1;
                                state_nxt_s = LOAD_A;
                            end else begin
                                state_nxt_s = FULL;
                            end
                        end else begin
                            cnt_nxt_s = cnt_r + CW'(1);
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                FULL: begin
                    if (m_ready) begin
                        load_s      = 1'b1;
                        state_nxt_s = LOAD_A;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = LOAD_A;
                    cnt_nxt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // FSM state, element counter and working register banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= LOAD_A;
            cnt_r    <= {CW{1'b0}};
            work_a_r <= {AW{1'b0}};
            work_b_r <= {BW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            work_a_r <= work_a_nxt_s;
            work_b_r <= work_b_nxt_s;
        end
    end

    // Output bank: loads a finished pair (including the element accepted this
    // edge), otherwise drops m_valid once downstream has taken the pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mat_a   <= {AW{1'b0}};
            mat_b   <= {BW{1'b0}};
            m_valid <= 1'b0;
        end else if (load_s) begin
            mat_a   <= work_a_nxt_s;
            mat_b   <= work_b_nxt_s;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end else begin
            m_valid <= m_valid;
        end
    end

endmodule

// File: tb/tb_cargador_matrices.sv
module tb_cargador_matrices;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [2:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] mat_a;
    logic [23:0] mat_b;
    logic        m_valid;
    logic        m_ready;

    int total;
    int bad;

    cargador_matrices #(.Bit(3), .M(4), .N(2), .P(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .mat_a   (mat_a),
        .mat_b   (mat_b),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Offer one element and wait (bounded) until it is accepted.
    task automatic push(input logic [2:0] v);
        bit done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int t = 0; t < 32 && !done; t++) begin
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("push_timeout", 24'd0, 24'd1);
    endtask

    // Stream indices lo..hi of the 16-element sequence A(0..7), B(8..15).
    task automatic push_range(input logic [23:0] a, input logic [23:0] b,
                              input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (i < 8) push(a[i*3 +: 3]);
            else       push(b[(i-8)*3 +: 3]);
        end
    endtask

    task automatic pulse_ready();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    initial begin
        logic [23:0] x_a, x_b, y_a, y_b, z_a, z_b, e_a, e_b;
        int acc, mv_hi;
        bit  miss;

        total = 0; bad = 0;
        rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = 3'd0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mat_a", mat_a, 24'd0);
        chk("rst_mat_b", mat_b, 24'd0);
        chk("rst_m_valid", {23'd0, m_valid}, 24'd0);
        chk("rst_s_ready", {23'd0, s_ready}, 24'd1);

        // Full load: A=1..7,0  B=7..0
        x_a = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        x_b = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        m_ready = 1'b1;
        push_range(x_a, x_b, 0, 14);
        chk("full_mv_before_last", {23'd0, m_valid}, 24'd0);
        push_range(x_a, x_b, 15, 15);
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("full_mv", {23'd0, m_valid}, 24'd1);
        chk("full_a_lo", {21'd0, mat_a[2:0]}, 24'd1);
        chk("full_a_hi", {21'd0, mat_a[23:21]}, 24'd0);
        chk("full_b_lo", {21'd0, mat_b[2:0]}, 24'd7);
        chk("full_b_hi", {21'd0, mat_b[23:21]}, 24'd0);
        chk("full_a", mat_a, x_a);
        chk("full_b", mat_b, x_b);

        // Back-pressure
        pulse_ready();
        chk("bp_drain_mv", {23'd0, m_valid}, 24'd0);
        x_a = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        x_b = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        y_a = 24'o33333333;
        y_b = 24'o55555555;
        push_range(x_a, x_b, 0, 15);
        push_range(y_a, y_b, 0, 15);
        chk("bp_s_ready_full", {23'd0, s_ready}, 24'd0);
        chk("bp_mv_held", {23'd0, m_valid}, 24'd1);
        chk("bp_a_held", mat_a, x_a);
        chk("bp_b_held", mat_b, x_b);
        s_valid = 1'b1; s_data = 3'd1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("bp_still_full", {23'd0, s_ready}, 24'd0);
        pulse_ready();
        chk("bp_a_second", mat_a, y_a);
        chk("bp_b_second", mat_b, y_b);
        chk("bp_s_ready_back", {23'd0, s_ready}, 24'd1);
        chk("bp_mv_second", {23'd0, m_valid}, 24'd1);

        // Back-to-back: 3 pairs, continuous s_valid, m_ready held high
        acc = 0; mv_hi = 0; miss = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 48; c++) begin
            s_valid = 1'b1;
            s_data  = 3'(((c % 16) * 3) + (c / 16));
            if (s_ready) acc++;
            @(posedge clk);
            #1;
            if (m_valid) mv_hi++;
            if ((c % 16) == 15 && !m_valid) miss = 1'b1;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e_a[i*3 +: 3] = 3'((i * 3) + 2);
            e_b[i*3 +: 3] = 3'(((i + 8) * 3) + 2);
        end
        chk("b2b_accepts", 24'(acc), 24'd48);
        chk("b2b_completion_mv", {23'd0, miss}, 24'd0);
        chk("b2b_mv_cycles", 24'(mv_hi), 24'd3);
        chk("b2b_a", mat_a, e_a);
        chk("b2b_b", mat_b, e_b);

        // clr after 5 A elements
        pulse_ready();
        push_range(24'o77777777, 24'o0, 0, 4);
        s_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_mv_untouched", {23'd0, m_valid}, 24'd0);
        chk("clr_a_untouched", mat_a, e_a);
        z_a = {3'd1, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        z_b = 24'o22222222;
        push_range(z_a, z_b, 0, 15);
        s_valid = 1'b0;
        chk("clr_fresh_mv", {23'd0, m_valid}, 24'd1);
        chk("clr_fresh_a", mat_a, z_a);
        chk("clr_fresh_b", mat_b, z_b);

        // clr coincident with an accept drops that element
        pulse_ready();
        push_range(24'o55555555, 24'o0, 0, 2);
        s_valid = 1'b1; s_data = 3'd5; clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        push_range(24'o66666666, 24'o11111111, 0, 14);
        chk("clr_acc_mv_15", {23'd0, m_valid}, 24'd0);
        push_range(24'o66666666, 24'o11111111, 15, 15);
        s_valid = 1'b0;
        chk("clr_acc_mv_16", {23'd0, m_valid}, 24'd1);
        chk("clr_acc_a", mat_a, 24'o66666666);
        chk("clr_acc_b", mat_b, 24'o11111111);

        // Async reset during LOAD_B
        push_range(24'o33333333, 24'o44444444, 0, 10);
        s_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_a", mat_a, 24'd0);
        chk("arst_b", mat_b, 24'd0);
        chk("arst_mv", {23'd0, m_valid}, 24'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_range(24'o11111115, 24'o33333333, 0, 15);
        s_valid = 1'b0;
        chk("arst_reload_mv", {23'd0, m_valid}, 24'd1);
        chk("arst_reload_a", mat_a, 24'o11111115);
        chk("arst_reload_b", mat_b, 24'o33333333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
